// File: rtl/axi_wr_issue_arbiter_if.sv
// Request/grant bundle between the crossbar write path and one master-port
// write issue arbiter.
interface axi_wr_issue_arbiter_if #(
    parameter int S_COUNT   = 4,
    parameter int M_ISSUE   = 4,
    parameter int CNT_WIDTH = $clog2(M_ISSUE + 1)
);
    localparam int IDX_W = $clog2(S_COUNT);

    logic [S_COUNT-1:0]   req;
    logic [S_COUNT-1:0]   grant;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_index;
    logic                 aw_hs;
    logic                 w_last_hs;
    logic                 b_hs;
    logic [CNT_WIDTH-1:0] outstanding;
    logic                 issue_full;
    logic                 err_underflow;
    logic                 timeout;

    // arbiter side
    modport slave (
        input  req, aw_hs, w_last_hs, b_hs,
        output grant, grant_valid, grant_index, outstanding,
               issue_full, err_underflow, timeout
    );

    // requester / master-handshake side
    modport master (
        output req, aw_hs, w_last_hs, b_hs,
        input  grant, grant_valid, grant_index, outstanding,
               issue_full, err_underflow, timeout
    );
endinterface

// File: rtl/axi_wr_issue_arbiter.sv
// Round-robin AW/W grant arbiter for one crossbar master port with an
// outstanding-write cap. Optional watchdog: define AXI_ARB_TIMEOUT_EN.
module axi_wr_issue_arbiter #(
    parameter int S_COUNT        = 4,
    parameter int M_ISSUE        = 4,
    parameter int CNT_WIDTH      = $clog2(M_ISSUE + 1),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_wr_issue_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(S_COUNT);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(S_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(M_ISSUE);

    typedef enum logic [1:0] {IDLE, GRANT, AW_DONE, W_DONE} state_t;

    state_t             state;
    logic [S_COUNT-1:0] grant_q;
    logic [IDX_W-1:0]   grant_idx_q;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_WIDTH-1:0] cnt;
    logic               err_q;

    logic [S_COUNT-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W-1:0]   nxt_ptr;
    int                 k;

    // first requester at or after ptr, wrapping
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        win_found = 1'b0;
        k         = 0;
        for (int i = 0; i < S_COUNT; i++) begin
            k = int'(ptr) + i;
            if (k >= S_COUNT) k = k - S_COUNT;
            if (!win_found && bus.req[k[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = k[IDX_W-1:0];
                win_oh    = '0;
                win_oh[k[IDX_W-1:0]] = 1'b1;
            end
        end
    end

    assign nxt_ptr = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found && !bus.issue_full) begin
                        state       <= GRANT;
                        grant_q     <= win_oh;
                        grant_idx_q <= win_idx;
                    end
                end
                GRANT: begin
                    if (bus.aw_hs && bus.w_last_hs) begin
                        state       <= IDLE;
                        grant_q     <= '0;
                        grant_idx_q <= '0;
                        ptr         <= nxt_ptr;
                    end else if (bus.aw_hs) begin
                        state <= AW_DONE;
                        ptr   <= nxt_ptr;
                    end else if (bus.w_last_hs) begin
                        state <= W_DONE;
                    end
                end
                AW_DONE: begin
                    if (bus.w_last_hs) begin
                        state       <= IDLE;
                        grant_q     <= '0;
                        grant_idx_q <= '0;
                    end
                end
                W_DONE: begin
                    if (bus.aw_hs) begin
                        state       <= IDLE;
                        grant_q     <= '0;
                        grant_idx_q <= '0;
                        ptr         <= nxt_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // AW counted in every state; saturate high, flag B with nothing outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (bus.aw_hs && !bus.b_hs) begin
            if (cnt != MAX_CNT) cnt <= cnt + 1'b1;
        end else if (bus.b_hs && !bus.aw_hs) begin
            if (cnt == '0) err_q <= 1'b1;
            else           cnt   <= cnt - 1'b1;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = |grant_q;
    assign bus.grant_index   = grant_idx_q;
    assign bus.outstanding   = cnt;
    assign bus.issue_full    = (cnt == MAX_CNT);
    assign bus.err_underflow = err_q;

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] tcnt;
    logic            timeout_q;

    // grant is never revoked here; the flag only reports a stuck burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else if (state == IDLE) begin
            tcnt <= '0;
        end else begin
            if (tcnt != TO_MAX) tcnt <= tcnt + 1'b1;
            if (tcnt == TO_MAX - 1'b1) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_issue_arbiter.sv
// Directed bench for axi_wr_issue_arbiter (S_COUNT=4, M_ISSUE=4, TIMEOUT_CYCLES=16).
module tb_axi_wr_issue_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    axi_wr_issue_arbiter_if #(.S_COUNT(4), .M_ISSUE(4), .CNT_WIDTH(3)) bus ();

    axi_wr_issue_arbiter #(
        .S_COUNT(4), .M_ISSUE(4), .CNT_WIDTH(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0; bus.aw_hs = 0; bus.w_last_hs = 0; bus.b_hs = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.aw_hs = 0; bus.w_last_hs = 0; bus.b_hs = 0;
        rst_n = 0;
        tick();
        tick();
        n_chk++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", bus.grant); else n_pass++;
        n_chk++; if (bus.grant_valid !== 1'b0) $display("FAIL reset_gvalid: got %b want 0", bus.grant_valid); else n_pass++;
        n_chk++; if (bus.grant_index !== 2'd0) $display("FAIL reset_gidx: got %0d want 0", bus.grant_index); else n_pass++;
        n_chk++; if (bus.outstanding !== 3'd0) $display("FAIL reset_outst: got %0d want 0", bus.outstanding); else n_pass++;
        n_chk++; if ({bus.issue_full, bus.err_underflow, bus.timeout} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {bus.issue_full, bus.err_underflow, bus.timeout}); else n_pass++;
        rst_n = 1;
        tick();
    endtask

    task automatic test_single();
        bus.req = 4'b0001;
        tick();
        n_chk++; if (bus.grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", bus.grant); else n_pass++;
        n_chk++; if (bus.grant_index !== 2'd0 || bus.grant_valid !== 1'b1)
            $display("FAIL single_idx: got idx %0d v %b want idx 0 v 1", bus.grant_index, bus.grant_valid); else n_pass++;
        bus.req = '0; bus.aw_hs = 1; bus.w_last_hs = 1;
        tick();
        bus.aw_hs = 0; bus.w_last_hs = 0;
        n_chk++; if (bus.grant !== 4'b0000) $display("FAIL single_release: got %b want 0000", bus.grant); else n_pass++;
        n_chk++; if (bus.outstanding !== 3'd1) $display("FAIL single_outst: got %0d want 1", bus.outstanding); else n_pass++;
        bus.b_hs = 1;
        tick();
        bus.b_hs = 0;
        n_chk++; if (bus.outstanding !== 3'd0) $display("FAIL single_bret: got %0d want 0", bus.outstanding); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        logic [3:0] oh;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            oh = 4'b0001 << order[n];
            n_chk++; if (bus.grant !== oh || bus.grant_index !== order[n])
                $display("FAIL rr_grant%0d: got %b idx %0d want %b idx %0d", n, bus.grant, bus.grant_index, oh, order[n]); else n_pass++;
            bus.aw_hs = 1;
            tick();
            bus.aw_hs = 0;
            n_chk++; if (bus.grant !== oh) $display("FAIL rr_hold%0d: got %b want %b", n, bus.grant, oh); else n_pass++;
            bus.w_last_hs = 1; bus.b_hs = 1;
            tick();
            bus.w_last_hs = 0; bus.b_hs = 0;
            n_chk++; if (bus.grant !== 4'b0000) $display("FAIL rr_drop%0d: got %b want 0000", n, bus.grant); else n_pass++;
        end
        bus.req = '0;
        n_chk++; if (bus.outstanding !== 3'd0) $display("FAIL rr_outst: got %0d want 0", bus.outstanding); else n_pass++;
    endtask

    task automatic test_issue_full();
        do_reset();
        bus.req = 4'b0001;
        for (int n = 0; n < 4; n++) begin
            tick();
            bus.aw_hs = 1; bus.w_last_hs = 1;
            tick();
            bus.aw_hs = 0; bus.w_last_hs = 0;
        end
        bus.req = 4'b0010;
        n_chk++; if (bus.outstanding !== 3'd4 || bus.issue_full !== 1'b1)
            $display("FAIL full_count: got %0d full %b want 4 full 1", bus.outstanding, bus.issue_full); else n_pass++;
        tick();
        tick();
        n_chk++; if (bus.grant !== 4'b0000) $display("FAIL full_block: got %b want 0000", bus.grant); else n_pass++;
        bus.b_hs = 1;
        tick();
        bus.b_hs = 0;
        n_chk++; if (bus.outstanding !== 3'd3 || bus.issue_full !== 1'b0)
            $display("FAIL full_bret: got %0d full %b want 3 full 0", bus.outstanding, bus.issue_full); else n_pass++;
        tick();
        n_chk++; if (bus.grant !== 4'b0010) $display("FAIL full_regrant: got %b want 0010", bus.grant); else n_pass++;
        bus.req = '0;
    endtask

    task automatic test_w_first();
        do_reset();
        bus.req = 4'b0100;
        tick();
        n_chk++; if (bus.grant !== 4'b0100 || bus.grant_index !== 2'd2)
            $display("FAIL wf_grant: got %b idx %0d want 0100 idx 2", bus.grant, bus.grant_index); else n_pass++;
        bus.w_last_hs = 1;
        tick();
        n_chk++; if (bus.grant !== 4'b0100) $display("FAIL wf_wdone: got %b want 0100", bus.grant); else n_pass++;
        bus.req = 4'b0001;
        tick();
        bus.w_last_hs = 0;
        n_chk++; if (bus.grant !== 4'b0100) $display("FAIL wf_ignore: got %b want 0100", bus.grant); else n_pass++;
        bus.aw_hs = 1; bus.req = '0;
        tick();
        bus.aw_hs = 0;
        n_chk++; if (bus.grant !== 4'b0000 || bus.outstanding !== 3'd1)
            $display("FAIL wf_done: got %b outst %0d want 0000 outst 1", bus.grant, bus.outstanding); else n_pass++;
        bus.req = 4'b1111;
        tick();
        n_chk++; if (bus.grant !== 4'b1000 || bus.grant_index !== 2'd3)
            $display("FAIL wf_ptr: got %b idx %0d want 1000 idx 3", bus.grant, bus.grant_index); else n_pass++;
        bus.req = '0;
    endtask

    task automatic test_underflow();
        do_reset();
        bus.b_hs = 1;
        tick();
        bus.b_hs = 0;
        n_chk++; if (bus.err_underflow !== 1'b1 || bus.outstanding !== 3'd0)
            $display("FAIL uf_flag: got err %b outst %0d want err 1 outst 0", bus.err_underflow, bus.outstanding); else n_pass++;
        bus.aw_hs = 1;
        tick();
        tick();
        bus.aw_hs = 0;
        n_chk++; if (bus.outstanding !== 3'd2 || bus.grant !== 4'b0000)
            $display("FAIL uf_idle_aw: got outst %0d grant %b want 2 0000", bus.outstanding, bus.grant); else n_pass++;
        bus.aw_hs = 1; bus.b_hs = 1;
        tick();
        bus.b_hs = 0;
        n_chk++; if (bus.outstanding !== 3'd2 || bus.err_underflow !== 1'b1)
            $display("FAIL uf_both: got outst %0d err %b want 2 err 1", bus.outstanding, bus.err_underflow); else n_pass++;
        tick();
        tick();
        tick();
        bus.aw_hs = 0;
        n_chk++; if (bus.outstanding !== 3'd4 || bus.issue_full !== 1'b1)
            $display("FAIL uf_saturate: got %0d full %b want 4 full 1", bus.outstanding, bus.issue_full); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.aw_hs = 1;
        tick();
        tick();
        bus.aw_hs = 0; bus.req = 4'b0001;
        tick();
        bus.aw_hs = 1; bus.req = '0;
        tick();
        bus.aw_hs = 0;
        n_chk++; if (bus.outstanding !== 3'd3 || bus.grant !== 4'b0001)
            $display("FAIL mid_setup: got outst %0d grant %b want 3 0001", bus.outstanding, bus.grant); else n_pass++;
        #2;
        rst_n = 0;
        #1;
        n_chk++; if ({bus.grant, bus.grant_valid, bus.grant_index, bus.outstanding, bus.issue_full, bus.err_underflow, bus.timeout} !== 14'd0)
            $display("FAIL mid_async: got grant %b outst %0d want all zero", bus.grant, bus.outstanding); else n_pass++;
        tick();
        rst_n = 1;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
`ifdef AXI_ARB_TIMEOUT_EN
        repeat (15) tick();
        n_chk++; if (bus.timeout !== 1'b0) $display("FAIL to_early: got %b want 0", bus.timeout); else n_pass++;
        tick();
        n_chk++; if (bus.timeout !== 1'b1 || bus.grant !== 4'b0001)
            $display("FAIL to_set: got to %b grant %b want 1 0001", bus.timeout, bus.grant); else n_pass++;
`else
        repeat (20) tick();
        n_chk++; if (bus.timeout !== 1'b0 || bus.grant !== 4'b0001)
            $display("FAIL to_off: got to %b grant %b want 0 0001", bus.timeout, bus.grant); else n_pass++;
`endif
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_issue_full();
        test_w_first();
        test_underflow();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axi_wr_issue_arbiter.md
Name: axi_wr_issue_arbiter

Overview:
Per-master-port write arbiter for the AXI crossbar write path. It shares one master interface between S_COUNT slave-interface requesters using round-robin arbitration. A grant is held until both the AW handshake and the final W beat (wlast) of the granted burst complete. Outstanding writes are capped at M_ISSUE by counting AW handshakes against B handshakes. The grant outputs drive the AW/W mux selects in the crossbar write datapath.

Parameters:
S_COUNT, 4, number of requesting slave interfaces (>=2)
M_ISSUE, 4, max outstanding writes (AW accepted, B not yet returned) on this master port
CNT_WIDTH, $clog2(M_ISSUE+1), width of the outstanding counter
TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  S_COUNT  per-requester AW valid decoded to this master port
grant  out  S_COUNT  one-hot grant, registered
grant_valid  out  1  OR of grant
grant_index  out  $clog2(S_COUNT)  binary index of the granted requester
aw_hs  in  1  master-side awvalid&awready
w_last_hs  in  1  master-side wvalid&wready&wlast
b_hs  in  1  master-side bvalid&bready
outstanding  out  CNT_WIDTH  current outstanding-write count
issue_full  out  1  outstanding==M_ISSUE
err_underflow  out  1  sticky: b_hs seen while outstanding==0
timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; grant=0; grant_valid=0; grant_index=0; outstanding=0; issue_full=0; err_underflow=0; timeout=0; round-robin pointer=0. Release is synchronous to clk.
- States:
  - IDLE: no grant.
  - GRANT: grant held; neither AW nor W-last done.
  - AW_DONE: AW done; waiting for W-last.
  - W_DONE: W-last done; waiting for AW.
- IDLE -> GRANT when req!=0 and issue_full=0. Winner is the first set req bit at or after the pointer, with wrap-around. The grant is registered: req sampled in cycle N gives grant in cycle N+1.
- GRANT:
  - aw_hs&w_last_hs -> IDLE.
  - aw_hs -> AW_DONE.
  - w_last_hs -> W_DONE.
- AW_DONE -> IDLE on w_last_hs.
- W_DONE -> IDLE on aw_hs.
- aw_hs in AW_DONE and w_last_hs in W_DONE are ignored (protocol violation, no state change).
- Grant deasserts in the cycle after completion. A new grant can appear no earlier than 2 cycles after the completing cycle.
- Pointer updates on the grant's aw_hs to (grant_index+1) mod S_COUNT.
- req changes while granted do not affect the grant; the grant is never revoked except by reset.
- outstanding:
  - +1 on aw_hs; -1 on b_hs; unchanged when both occur in the same cycle.
  - aw_hs is counted in any state, including one arriving at issue_full (saturates at M_ISSUE, no wrap).
  - b_hs at 0 keeps the count at 0 and sets err_underflow.
- issue_full blocks only new grants; an active grant proceeds to completion.
- aw_hs/w_last_hs/b_hs while IDLE: only the counter and flag rules above apply; state does not change.

Optional Feature:
AXI_ARB_TIMEOUT_EN:
- Defined: a cycle counter runs while state!=IDLE and clears on entry to IDLE. On reaching TIMEOUT_CYCLES, timeout is set and stays set until reset. The grant is not released.
- Undefined: no counter is built and timeout is tied to 0.

Test Plan:
- Reset then req=4'b0001 -> grant=0001 and grant_index=0 one cycle later. Then aw_hs and w_last_hs in the same cycle -> grant=0 next cycle, outstanding=1.
- req=4'b1111 held, each burst completed via aw_hs then w_last_hs, b_hs each time -> grant order 0,1,2,3,0. Outstanding returns to 0.
- M_ISSUE=4: four bursts without b_hs -> outstanding=4, issue_full=1, req=0010 gets no grant. One b_hs -> outstanding=3, grant=0010 next cycle.
- Granted requester 2: w_last_hs before aw_hs -> state W_DONE, grant held. Then aw_hs -> grant drops, pointer=3.
- b_hs with outstanding=0 -> err_underflow=1, outstanding stays 0. Simultaneous aw_hs&b_hs at outstanding=2 -> remains 2.
- rst_n low mid-burst (state AW_DONE, outstanding=3) -> all outputs 0 immediately without a clock edge. With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, a grant held 16 cycles -> timeout=1.
